// File: rtl/cy10lp_pio_in_debounce.sv
// -----------------------------------------------------------------------------
// cy10lp_pio_in_debounce
//
// Avalon-MM slave input PIO. Board push-buttons and switches are synchronised
// (2-FF), debounced per bit and edge-detected. Detected edges set sticky
// EDGECAPTURE bits, and any captured bit enabled in IRQMASK raises a level
// interrupt. Reads are registered, so they have a fixed latency of 1 cycle.
//
// Register map (word addresses):
//   0 DATA        RO  debounced input value
//   1 reserved        reads 0, writes ignored
//   2 IRQMASK     RW  per-bit interrupt enable
//   3 EDGECAPTURE RO  write 1 to clear a bit
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   address_i    register select (word address)
//   chipselect_i slave select
//   write_n_i    active-low write strobe
//   writedata_i  write data
//   in_port_i    asynchronous board inputs
//   readdata_o   registered read data, zero-extended to 32 bits
//   irq_o        registered level interrupt
// -----------------------------------------------------------------------------
module cy10lp_pio_in_debounce #(
  parameter int unsigned           WIDTH           = 16,
  parameter int unsigned           DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0]      IDLE_VALUE      = {WIDTH{1'b1}},
  parameter int unsigned           EDGE_TYPE       = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       address_i,
  input  logic             chipselect_i,
  input  logic             write_n_i,
  input  logic [31:0]      writedata_i,
  input  logic [WIDTH-1:0] in_port_i,
  output logic [31:0]      readdata_o,
  output logic             irq_o
);

  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrIrqMask = 2'd2;
  localparam logic [1:0] AddrEdgeCap = 2'd3;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic rd_en;

  assign wr_en = chipselect_i & ~write_n_i;
  assign rd_en = chipselect_i & write_n_i;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Both stages idle at IDLE_VALUE so that a reset with
  // the inputs at rest produces no transition downstream.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= IDLE_VALUE;
      sync2_q <= IDLE_VALUE;
    end else begin
      sync1_q <= in_port_i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] deb_val;

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    assign deb_val = sync2_q;
  end else begin : g_debounce
    localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           deb_q, deb_d;

    // A bit must differ from the debounced value for DEBOUNCE_CYCLES
    // consecutive cycles (counter values 0..CntLast) before it is accepted.
    // The >= compare means the counter can never run past its terminal value.
    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= CntLast) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_q <= '0;
        deb_q <= IDLE_VALUE;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb_val = deb_q;
  end

  // ---------------------------------------------------------------------------
  // Edge detection and capture
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = prev_q & ~deb_val;
      1:       edge_det = ~prev_q & deb_val;
      default: edge_det = prev_q ^ deb_val;
    endcase
  end

  assign edge_clr = (wr_en && (address_i == AddrEdgeCap)) ? writedata_i[WIDTH-1:0] : '0;

  // Set has priority over a simultaneous write-1-to-clear so no edge is lost.
  assign edge_cap_d = (edge_cap_q & ~edge_clr) | edge_det;

  assign irq_mask_d = (wr_en && (address_i == AddrIrqMask)) ? writedata_i[WIDTH-1:0]
                                                             : irq_mask_q;

  assign irq_d = |(edge_cap_q & irq_mask_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q     <= IDLE_VALUE;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= deb_val;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;

  // ---------------------------------------------------------------------------
  // Registered read path (latency 1, holds when not selected)
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rdata_sel;

  always_comb begin
    case (address_i)
      AddrData:    rdata_sel = 32'(deb_val);
      AddrIrqMask: rdata_sel = 32'(irq_mask_q);
      AddrEdgeCap: rdata_sel = 32'(edge_cap_q);
      default:     rdata_sel = 32'h0;
    endcase
  end

  assign rdata_d = rd_en ? rdata_sel : rdata_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= 32'h0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign readdata_o = rdata_q;

endmodule
